// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit
//
// Takes a fetch address from the PC stage, issues one read on a simple
// AXI-lite style read channel (AR then R), and hands the returned word to
// the decode stage. At most one fetch is in flight at any time.
//
// Parameters:
//   BITWIDTH    instruction/address width (default 32)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   pc          fetch address from the PC stage
//   pc_valid    pc holds a new fetch address
//   ifu_ready   IFU can accept a new pc (IDLE)
//   flush       redirect: discard the in-flight fetch
//   araddr      memory read address
//   arvalid     read address valid (AR)
//   arready     memory accepts the address
//   rdata       read data
//   rresp       read response, nonzero means error
//   rvalid      read data valid
//   rready      IFU accepts read data (R)
//   inst        fetched instruction
//   inst_pc     address of inst
//   inst_valid  inst/inst_pc/inst_fault are valid for decode (OUT)
//   inst_ready  decode stage accepts inst
//   inst_fault  fetch faulted
//
// Optional feature:
//   IFU_FAULT_CHECK_EN  when defined, misaligned fetch addresses skip the
//                       memory access and fault, and an error response on
//                       the read channel marks the instruction as faulted.
//                       When undefined, inst_fault is tied low and rresp is
//                       ignored.
// ---------------------------------------------------------------------------
module ifu #(
    parameter int unsigned BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITWIDTH-1:0] pc,
    input  logic                pc_valid,
    output logic                ifu_ready,
    input  logic                flush,
    output logic [BITWIDTH-1:0] araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [31:0]         inst,
    output logic [BITWIDTH-1:0] inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic                inst_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic                drop_q, drop_d;
    logic [BITWIDTH-1:0] pc_q, pc_d;
    logic [31:0]         inst_q, inst_d;
    logic [BITWIDTH-1:0] inst_pc_q, inst_pc_d;

`ifdef IFU_FAULT_CHECK_EN
    logic                fault_q, fault_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
`ifdef IFU_FAULT_CHECK_EN
        fault_d   = fault_q;
`endif

        case (state_q)
            S_IDLE: begin
                // flush has no meaning here: nothing is in flight, and a
                // pc presented together with flush is the redirect target.
                if (pc_valid) begin
                    pc_d = pc;
`ifdef IFU_FAULT_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        state_d   = S_OUT;
                        inst_d    = '0;
                        inst_pc_d = pc;
                        fault_d   = 1'b1;
                    end else begin
                        state_d   = S_AR;
                    end
`else
                    state_d = S_AR;
`endif
                end
            end

            S_AR: begin
                // The address handshake cannot be withdrawn once raised, so
                // a flush only marks the eventual data beat for discard.
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (arready) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                if (rvalid) begin
                    // A flush arriving on the same cycle as the beat counts
                    // as well as one recorded earlier.
                    if (drop_q || flush) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d   = S_OUT;
                        inst_d    = rdata;
                        inst_pc_d = pc_q;
`ifdef IFU_FAULT_CHECK_EN
                        fault_d   = (rresp != 2'b00);
`endif
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end

            S_OUT: begin
                // Decode ignores inst_valid during flush, so leaving on
                // flush alone is safe even if inst_ready is also high.
                if (flush || inst_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            drop_q    <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef IFU_FAULT_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign inst_fault = fault_q;
`else
    logic unused_rresp;

    assign unused_rresp = ^rresp;
    assign inst_fault   = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs: handshake strobes decoded from registered state only
    // -----------------------------------------------------------------------
    assign ifu_ready  = (state_q == S_IDLE);
    assign arvalid    = (state_q == S_AR);
    assign rready     = (state_q == S_R);
    assign inst_valid = (state_q == S_OUT);

    assign araddr     = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu -- directed scoreboard bench for ifu
//
// Stimulus pushes the expected decode-side transaction into a queue; a
// monitor pops and compares whenever the decode handshake completes.
// Timing/handshake properties are checked directly in the stimulus thread.
// ---------------------------------------------------------------------------
module tb_ifu;

    localparam int BW = 32;

`ifdef IFU_FAULT_CHECK_EN
    localparam logic FAULT_EN = 1'b1;
`else
    localparam logic FAULT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [BW-1:0] pc;
    logic          pc_valid;
    logic          ifu_ready;
    logic          flush;
    logic [BW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [31:0]   inst;
    logic [BW-1:0] inst_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic          inst_fault;

    ifu #(.BITWIDTH(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .ifu_ready  (ifu_ready),
        .flush      (flush),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_fault (inst_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]   inst;
        logic [BW-1:0] ipc;
        logic          fault;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Decode-side monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && inst_valid && inst_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("unexpected_inst_valid", inst_valid, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_inst", inst, e.inst);
                chk("sb_inst_pc", inst_pc, e.ipc);
                chk("sb_inst_fault", inst_fault, e.fault);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (ifu_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, ifu_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; pc = '0; pc_valid = 0; flush = 0; arready = 0;
        rdata = '0; rresp = '0; rvalid = 0; inst_ready = 1;

        // Reset state
        repeat (2) smp();
        chk("rst_ifu_ready", ifu_ready, 1);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_fault", inst_fault, 0);
        cyc(); rst = 1'b1;
        cyc();

        // Basic fetch, three-cycle latency
        cyc(); pc = 32'h8000_0000; pc_valid = 1; arready = 1; rvalid = 1;
        rdata = 32'h0000_0413; inst_ready = 1;
        sb.push_back('{32'h0000_0413, 32'h8000_0000, 1'b0});
        smp(); chk("t1_c0_ifu_ready", ifu_ready, 1);
        cyc(); pc_valid = 0;
        smp(); chk("t1_c1_arvalid", arvalid, 1); chk("t1_c1_araddr", araddr, 32'h8000_0000);
        smp(); chk("t1_c2_rready", rready, 1); chk("t1_c2_inst_valid", inst_valid, 0);
        smp(); chk("t1_c3_inst_valid", inst_valid, 1);
        smp(); chk("t1_c4_ifu_ready", ifu_ready, 1);
        cyc(); rvalid = 0; arready = 0;

        // AR stall for 5 cycles
        cyc(); pc = 32'h8000_0004; pc_valid = 1; rdata = 32'h0010_0093;
        sb.push_back('{32'h0010_0093, 32'h8000_0004, 1'b0});
        cyc(); pc_valid = 0; pc = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) smp();
            chk("t2_stall_arvalid", arvalid, 1);
            chk("t2_stall_araddr", araddr, 32'h8000_0004);
        end
        cyc(); arready = 1;
        smp(); chk("t2_accept_arvalid", arvalid, 1);
        cyc(); arready = 0; rvalid = 1;
        smp(); chk("t2_rready", rready, 1);
        cyc(); rvalid = 0;
        wait_idle("t2_idle");

        // Decode back-pressure in OUT
        cyc(); pc = 32'h8000_0008; pc_valid = 1; arready = 1; rvalid = 1;
        rdata = 32'h1234_5678; inst_ready = 0;
        sb.push_back('{32'h1234_5678, 32'h8000_0008, 1'b0});
        cyc(); pc_valid = 0;
        smp(); smp();
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t3_hold_inst_valid", inst_valid, 1);
            chk("t3_hold_inst", inst, 32'h1234_5678);
            chk("t3_hold_inst_pc", inst_pc, 32'h8000_0008);
            chk("t3_hold_ifu_ready", ifu_ready, 0);
        end
        cyc(); inst_ready = 1;
        smp(); chk("t3_release_inst_valid", inst_valid, 1);
        smp(); chk("t3_release_ifu_ready", ifu_ready, 1);
        cyc(); arready = 0; rvalid = 0;

        // Flush in R: beat is dropped
        cyc(); pc = 32'h8000_000C; pc_valid = 1; arready = 1; rvalid = 0;
        cyc(); pc_valid = 0;
        cyc(); flush = 1;
        smp(); chk("t4_rready", rready, 1);
        cyc(); flush = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
        smp(); chk("t4_beat_rready", rready, 1); chk("t4_beat_inst_valid", inst_valid, 0);
        cyc(); rvalid = 0;
        smp(); chk("t4_after_ifu_ready", ifu_ready, 1); chk("t4_after_inst_valid", inst_valid, 0);

        // Flush+pc_valid in IDLE captures pc; flush in OUT with inst_ready
        cyc(); pc = 32'h8000_0010; pc_valid = 1; flush = 1; arready = 1; rvalid = 1;
        rdata = 32'hAAAA_5555; inst_ready = 1;
        cyc(); pc_valid = 0; flush = 0;
        smp(); chk("t5_arvalid", arvalid, 1); chk("t5_araddr", araddr, 32'h8000_0010);
        cyc();
        cyc(); flush = 1;
        smp(); chk("t5_out_inst_valid", inst_valid, 1);
        cyc(); flush = 0; rvalid = 0;
        smp(); chk("t5_idle_ifu_ready", ifu_ready, 1); chk("t5_idle_inst_valid", inst_valid, 0);

        // Error response
        cyc(); pc = 32'h8000_0018; pc_valid = 1; arready = 1; rvalid = 1;
        rresp = 2'b10; rdata = 32'hCAFE_F00D;
        sb.push_back('{32'hCAFE_F00D, 32'h8000_0018, FAULT_EN});
        cyc(); pc_valid = 0;
        smp(); smp();
        smp(); chk("t6_inst_fault", inst_fault, FAULT_EN);
        cyc(); rresp = 2'b00; rvalid = 0;
        wait_idle("t6_idle");

`ifdef IFU_FAULT_CHECK_EN
        // Misaligned pc skips the memory access
        cyc(); pc = 32'h8000_0002; pc_valid = 1; arready = 1; rvalid = 1;
        rdata = 32'hFFFF_FFFF;
        sb.push_back('{32'h0000_0000, 32'h8000_0002, 1'b1});
        cyc(); pc_valid = 0;
        smp(); chk("t7_arvalid", arvalid, 0); chk("t7_inst_valid", inst_valid, 1);
        chk("t7_inst", inst, 0); chk("t7_inst_fault", inst_fault, 1);
        cyc(); rvalid = 0;
        smp(); chk("t7_ifu_ready", ifu_ready, 1);
`endif

        // Asynchronous reset mid-R
        cyc(); pc = 32'h8000_001C; pc_valid = 1; arready = 1; rvalid = 0;
        cyc(); pc_valid = 0;
        cyc();
        smp(); chk("t8_pre_rready", rready, 1);
        #2 rst = 1'b0;
        #1;
        chk("t8_rst_arvalid", arvalid, 0);
        chk("t8_rst_rready", rready, 0);
        chk("t8_rst_inst_valid", inst_valid, 0);
        chk("t8_rst_ifu_ready", ifu_ready, 1);
        rvalid = 1; rdata = 32'h1111_1111;
        smp(); rvalid = 0;
        #1 rst = 1'b1;
        smp();
        chk("t8_post_ifu_ready", ifu_ready, 1);
        chk("t8_post_inst_valid", inst_valid, 0);
        chk("t8_post_inst", inst, 0);

        cyc();
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, the instruction and address width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port pc  input  BITWIDTH  fetch address from the PC stage.
REQ-005 SHALL have port pc_valid  input  1  pc holds a new fetch address.
REQ-006 SHALL have port ifu_ready  output  1  IFU can accept a new pc.
REQ-007 SHALL have port flush  input  1  redirect; discard the in-flight fetch.
REQ-008 SHALL have port araddr  output  BITWIDTH  memory read address.
REQ-009 SHALL have port arvalid  output  1  read address valid.
REQ-010 SHALL have port arready  input  1  memory accepts the address.
REQ-011 SHALL have port rdata  input  32  read data.
REQ-012 SHALL have port rresp  input  2  read response; nonzero means error.
REQ-013 SHALL have port rvalid  input  1  read data valid.
REQ-014 SHALL have port rready  output  1  IFU accepts read data.
REQ-015 SHALL have port inst  output  32  fetched instruction.
REQ-016 SHALL have port inst_pc  output  BITWIDTH  address of inst.
REQ-017 SHALL have port inst_valid  output  1  inst and inst_pc are valid for the decode stage.
REQ-018 SHALL have port inst_ready  input  1  decode stage accepts inst.
REQ-019 SHALL have port inst_fault  output  1  the fetch faulted (see Configuration).

Function
REQ-020 SHALL implement a four-state FSM: IDLE, AR, R, OUT; at most one transaction outstanding.
REQ-021 IDLE: ifu_ready=1; when pc_valid=1, SHALL register pc into pc_q and move to AR next cycle.
REQ-022 AR: arvalid=1 and araddr=pc_q; when arready=1, SHALL move to R; arvalid and araddr SHALL stay stable until accepted.
REQ-023 R: rready=1; when rvalid=1, SHALL register inst=rdata and inst_pc=pc_q and move to OUT.
REQ-024 OUT: inst_valid=1; inst, inst_pc and inst_fault SHALL hold stable; when inst_ready=1, SHALL return to IDLE.
REQ-025 Latency: with arready and rvalid held high and inst_ready=1, pc_valid at cycle 0 SHALL give inst_valid at cycle 3 and ifu_ready again at cycle 4.
REQ-026 ifu_ready, arvalid, rready and inst_valid SHALL each be asserted only in their own state, decoded from registered state only.
REQ-027 Flush in IDLE SHALL have no effect; flush and pc_valid in the same cycle SHALL still capture pc.
REQ-028 Flush in AR SHALL set a drop flag and keep arvalid until accepted; flush in R SHALL set the drop flag.
REQ-029 With the drop flag set, the rvalid beat SHALL be consumed and the FSM SHALL go from R to IDLE without entering OUT, clearing the flag.
REQ-030 Flush in OUT SHALL go to IDLE next cycle even if inst_ready=1 that cycle; the decode stage SHALL ignore inst_valid while flush=1.

Reset
REQ-031 With rst=0, SHALL immediately force state=IDLE, drop flag=0, pc_q=0, inst=0, inst_pc=0 and inst_fault=0, and deassert arvalid, rready and inst_valid; ifu_ready SHALL read 1.
REQ-032 Reset mid-transaction SHALL abandon the transaction; the memory side SHALL be reset by the same rst.

Configuration
REQ-033 Macro IFU_FAULT_CHECK_EN, when defined: a captured pc with pc[1:0]!=0 SHALL skip AR/R and go directly to OUT with inst=0 and inst_fault=1.
REQ-034 With IFU_FAULT_CHECK_EN defined, a non-dropped beat with rresp!=0 SHALL enter OUT with inst=rdata and inst_fault=1.
REQ-035 Without IFU_FAULT_CHECK_EN: inst_fault SHALL be tied to 0, araddr SHALL carry pc_q unmodified, and rresp SHALL be ignored.

Verification
REQ-036 pc=0x80000000 with pc_valid; arready=rvalid=1, rdata=0x00000413 -> inst_valid at cycle 3 with inst=0x00000413, inst_pc=0x80000000.
REQ-037 arready held 0 for 5 cycles -> arvalid=1 and araddr stable for all 5 cycles; then normal completion.
REQ-038 inst_ready=0 for 4 cycles in OUT -> inst/inst_pc stable and ifu_ready=0 throughout; IDLE one cycle after inst_ready=1.
REQ-039 flush in R, then rvalid with 0xDEADBEEF -> no inst_valid; ifu_ready=1 the cycle after the beat.
REQ-040 With the macro: pc=0x80000002 -> no arvalid, inst_fault=1, inst=0; rresp=2'b10 -> inst_fault=1. Without the macro: rresp=2'b10 -> inst_fault=0.
REQ-041 rst=0 asserted asynchronously mid-R -> arvalid=rready=inst_valid=0 immediately; ifu_ready=1.
